// File: rtl/rotor_key_loader.sv
// Loads NUM_ROTORS rotor start positions from ASCII key characters onto the rotor configuration bus.
// Latency: each accepted character drives one WRITE cycle on the edge after it is accepted; done follows the last WRITE.
// Backpressure: char_ready is high only in WAIT_CHAR; a character transfers when char_valid and char_ready are both high.
module rotor_key_loader #(
  parameter int          NUM_ROTORS = 3,
  parameter logic [1:0]  IDLE_SEL   = 2'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [4:0] pozitie_initiala_out,
  output logic [1:0] pozitie_rotor_out,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_ROTORS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CHAR,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] idx;
  logic [1:0] idx_nx;
  logic [4:0] pos_reg;
  logic [4:0] pos_nx;

  // Next values for the registered outputs, derived from the next state so
  // every output lines up with the state it belongs to without extra delay.
  logic [1:0] sel_nx;
  logic [4:0] ipos_nx;
  logic       busy_nx;
  logic       done_nx;
  logic       error_nx;

  logic       is_upper;
  logic       is_lower;
  logic [7:0] char_off;
  logic       xfer;

  // Classify the key byte and compute its alphabet offset.
  always_comb begin
    is_upper = (char_in >= 8'h41) && (char_in <= 8'h5A);
    is_lower = (char_in >= 8'h61) && (char_in <= 8'h7A);
    char_off = is_upper ? (char_in - 8'h41) : (char_in - 8'h61);
  end

  // char_ready comes straight from the state register.
  assign char_ready = (state == S_WAIT_CHAR);
  assign xfer       = char_valid && char_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state, index/position update and next output values.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    pos_nx   = pos_reg;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_WAIT_CHAR;
          idx_nx   = 2'd0;
        end
      end
      S_WAIT_CHAR: begin
        // start is deliberately ignored here: a load in progress never restarts.
        if (xfer) begin
          if (is_upper || is_lower) begin
            pos_nx   = char_off[4:0];
            state_nx = S_WRITE;
          end else begin
            state_nx = S_ERROR;
          end
        end
      end
      S_WRITE: begin
        if (idx == LAST_IDX) begin
          state_nx = S_DONE;
        end else begin
          idx_nx   = idx + 2'd1;
          state_nx = S_WAIT_CHAR;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      S_ERROR: begin
        if (start) begin
          state_nx = S_WAIT_CHAR;
          idx_nx   = 2'd0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        idx_nx   = 2'd0;
      end
    endcase

    // Only the WRITE cycle addresses a rotor; all other cycles park the bus.
    sel_nx   = (state_nx == S_WRITE) ? idx_nx : IDLE_SEL;
    ipos_nx  = (state_nx == S_WRITE) ? pos_nx : 5'd0;
    busy_nx  = (state_nx == S_WAIT_CHAR) || (state_nx == S_WRITE);
    done_nx  = (state_nx == S_DONE);
    error_nx = (state_nx == S_ERROR);
  end

  // Rotor index and captured position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= 2'd0;
      pos_reg <= 5'd0;
    end else begin
      idx     <= idx_nx;
      pos_reg <= pos_nx;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pozitie_initiala_out <= 5'd0;
      pozitie_rotor_out    <= IDLE_SEL;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      error                <= 1'b0;
    end else begin
      pozitie_initiala_out <= ipos_nx;
      pozitie_rotor_out    <= sel_nx;
      busy                 <= busy_nx;
      done                 <= done_nx;
      error                <= error_nx;
    end
  end

endmodule

// File: doc/rotor_key_loader.md
ROTOR_KEY_LOADER -- requirements
Module: rotor_key_loader

Interface
REQ-001 SHALL have parameter NUM_ROTORS, default 3, meaning the number of rotor positions loaded per key (legal range 1..3).
REQ-002 SHALL have parameter IDLE_SEL, default 2'd3, meaning the rotor-select code that addresses no rotor.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a key load.
REQ-006 SHALL have port char_in, input, 8, the ASCII key character.
REQ-007 SHALL have port char_valid, input, 1, meaning char_in is valid.
REQ-008 SHALL have port char_ready, output, 1, meaning the block accepts char_in this cycle.
REQ-009 SHALL have port pozitie_initiala_out, output, 5, the rotor start position 0..25 driven onto the rotor configuration bus.
REQ-010 SHALL have port pozitie_rotor_out, output, 2, the rotor-select (enable) code on the rotor configuration bus.
REQ-011 SHALL have port busy, output, 1, meaning a load is in progress.
REQ-012 SHALL have port done, output, 1, a one-cycle pulse when all NUM_ROTORS positions have been written.
REQ-013 SHALL have port error, output, 1, a sticky flag for a rejected character.

Function
REQ-014 SHALL implement the states IDLE, WAIT_CHAR, WRITE, DONE and ERROR, with a rotor index register idx of 2 bits.
REQ-015 In IDLE, SHALL drive char_ready=0, busy=0 and pozitie_rotor_out=IDLE_SEL, and SHALL go to WAIT_CHAR with idx=0 on start=1.
REQ-016 In WAIT_CHAR, SHALL drive char_ready=1 and busy=1; a transfer occurs only on a cycle with char_valid=1 and char_ready=1.
REQ-017 On a transfer of 'A'..'Z' (0x41..0x5A), SHALL register the position char_in-0x41; on 'a'..'z' (0x61..0x7A), SHALL register char_in-0x61; the result is truncated to 5 bits and always lies in 0..25.
REQ-018 On a transfer of any other byte, SHALL go to ERROR without writing any rotor.
REQ-019 After a legal transfer at edge N, SHALL be in WRITE for exactly the cycle after edge N, driving pozitie_rotor_out=idx and pozitie_initiala_out=the registered position, with char_ready=0.
REQ-020 From WRITE, SHALL go to DONE if idx==NUM_ROTORS-1; otherwise SHALL increment idx and return to WAIT_CHAR.
REQ-021 In DONE, SHALL assert done=1 for exactly one cycle with pozitie_rotor_out=IDLE_SEL, and SHALL then return to IDLE.
REQ-022 In ERROR, SHALL hold error=1, busy=0, char_ready=0 and pozitie_rotor_out=IDLE_SEL until start=1, which SHALL clear error and enter WAIT_CHAR with idx=0.
REQ-023 SHALL ignore start whenever busy=1; a load in progress is never restarted or aborted by start.
REQ-024 In every state other than WRITE, SHALL drive pozitie_initiala_out=0 and pozitie_rotor_out=IDLE_SEL, so rotors hold their values.
REQ-025 All outputs except char_ready SHALL be driven directly from registers; char_ready SHALL be decoded from the state register only.
REQ-026 SHALL write rotors strictly in index order 0..NUM_ROTORS-1, one rotor per accepted character.

Reset
REQ-027 While rst=1, SHALL force state=IDLE, idx=0, the position register=0, pozitie_initiala_out=0, pozitie_rotor_out=IDLE_SEL, char_ready=0, busy=0, done=0 and error=0.
REQ-028 Assertion of rst in the middle of a load SHALL abandon it immediately; no further rotor is written and no done pulse occurs.
REQ-029 After rst is released, SHALL remain in IDLE until the next start.

Verification
REQ-030 Nominal: start, then 'B','Q','z' with char_valid held high -> WRITE cycles show (sel=0,pos=1), (sel=1,pos=16), (sel=2,pos=25), then exactly one done pulse, then IDLE.
REQ-031 Backpressure/gaps: char_valid is low for 5 cycles between characters -> no WRITE occurs during the gaps, sel stays 3, and the final positions are unchanged.
REQ-032 Illegal byte: start, 'C', then '5' (0x35) -> exactly one WRITE (sel=0,pos=2), then error=1 and sel=3; a later start clears error and restarts at idx=0.
REQ-033 start is pulsed during WAIT_CHAR for idx=1 -> the pulse is ignored, idx stays 1, and the load completes normally.
REQ-034 rst is asserted in the WRITE cycle of idx=1 -> all outputs go to their reset values asynchronously, done never pulses, and a fresh load afterwards begins at sel=0.
REQ-035 Run with NUM_ROTORS=1: start, 'A' -> a single WRITE (sel=0,pos=0) followed by done on the next cycle.
